i2c_arbiter: RTL

Shares one i2c_master between NUM_REQ independent transaction requesters, for example the board bringup sequencer and a runtime PMIC/USB-C status poller.
- Requesters submit complete transactions: address, write bytes, and write/read lengths.
- The arbiter grants round-robin, drives the master's transfer inputs, and pulses start.
- It tracks busy to completion and returns read data and status to the owning requester.
- A watchdog prevents a wedged transfer from locking the bus forever.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/i2c_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C arbiter slice.
package i2c_pkg;

  localparam int MAX_TRANSFER = 4;
  localparam int LEN_W        = $clog2(MAX_TRANSFER + 1);
  localparam int DATA_W       = MAX_TRANSFER * 8;

  localparam logic [6:0] MXL7704_BUS_ADDR = 7'h2D;
  localparam logic [6:0] FUSB307_BUS_ADDR = 7'h52;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_XFER      = 3'd3,
    ST_RESP      = 3'd4,
    ST_DRAIN     = 3'd5
  } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Request/response bundle between requesters, the arbiter and the i2c_master.
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import i2c_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*7-1:0]       req_address;
  logic [NUM_REQ*DATA_W-1:0]  req_write_data;
  logic [NUM_REQ*LEN_W-1:0]   req_write_length;
  logic [NUM_REQ*LEN_W-1:0]   req_read_length;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]          rsp_read_data;
  logic                       rsp_no_response;
  logic                       rsp_timeout;
  logic [6:0]                 m_address;
  logic [DATA_W-1:0]          m_write_data;
  logic [LEN_W-1:0]           m_write_length;
  logic [LEN_W-1:0]           m_read_length;
  logic                       m_start;
  logic                       m_busy;
  logic                       m_no_response;
  logic [DATA_W-1:0]          m_read_data;

  // Arbiter side: accepts requests, drives the master.
  modport slave (
    input  req_valid, req_address, req_write_data, req_write_length, req_read_length,
    input  m_busy, m_no_response, m_read_data,
    output req_ready, rsp_valid, rsp_read_data, rsp_no_response, rsp_timeout,
    output m_address, m_write_data, m_write_length, m_read_length, m_start
  );

  // Environment side: requesters plus the i2c_master.
  modport master (
    output req_valid, req_address, req_write_data, req_write_length, req_read_length,
    output m_busy, m_no_response, m_read_data,
    input  req_ready, rsp_valid, rsp_read_data, rsp_no_response, rsp_timeout,
    input  m_address, m_write_data, m_write_length, m_read_length, m_start
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any
);

  int w_idx;
  int w_pick;

  // Scan from farthest to nearest so the candidate closest to i_ptr wins.
  always_comb begin
    w_idx  = 0;
    w_pick = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx  = (int'(i_ptr) + k) % NUM_REQ;
      w_pick = i_valid[w_idx] ? w_idx : w_pick;
    end
  end

  assign o_winner = IDX_W'(w_pick);
  assign o_any    = |i_valid;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sharing of one i2c_master between NUM_REQ transaction requesters,
// with a start-to-busy-fall watchdog.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  i2c_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1'b1);
  localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1'b1);

  arb_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_req_ready, w_req_ready_nxt;
  logic                r_m_start, w_m_start_nxt;
  logic [6:0]          r_m_address, w_m_address_nxt;
  logic [DATA_W-1:0]   r_m_write_data, w_m_write_data_nxt;
  logic [LEN_W-1:0]    r_m_wlen, w_m_wlen_nxt;
  logic [LEN_W-1:0]    r_m_rlen, w_m_rlen_nxt;
  logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_read_data, w_rsp_read_data_nxt;
  logic                r_rsp_nr, w_rsp_nr_nxt;
  logic                r_rsp_to, w_rsp_to_nxt;

  logic [IDX_W-1:0]    w_win;
  logic                w_any;
  logic                w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_valid  (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_any    (w_any)
  );

  assign w_timeout = (r_cnt == CNT_LAST);

  // State and all output/holding registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_ptr           <= {IDX_W{1'b0}};
      r_owner         <= {IDX_W{1'b0}};
      r_cnt           <= {CNT_W{1'b0}};
      r_req_ready     <= {NUM_REQ{1'b0}};
      r_m_start       <= 1'b0;
      r_m_address     <= 7'd0;
      r_m_write_data  <= {DATA_W{1'b0}};
      r_m_wlen        <= {LEN_W{1'b0}};
      r_m_rlen        <= {LEN_W{1'b0}};
      r_rsp_valid     <= {NUM_REQ{1'b0}};
      r_rsp_read_data <= {DATA_W{1'b0}};
      r_rsp_nr        <= 1'b0;
      r_rsp_to        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_ptr           <= w_ptr_nxt;
      r_owner         <= w_owner_nxt;
      r_cnt           <= w_cnt_nxt;
      r_req_ready     <= w_req_ready_nxt;
      r_m_start       <= w_m_start_nxt;
      r_m_address     <= w_m_address_nxt;
      r_m_write_data  <= w_m_write_data_nxt;
      r_m_wlen        <= w_m_wlen_nxt;
      r_m_rlen        <= w_m_rlen_nxt;
      r_rsp_valid     <= w_rsp_valid_nxt;
      r_rsp_read_data <= w_rsp_read_data_nxt;
      r_rsp_nr        <= w_rsp_nr_nxt;
      r_rsp_to        <= w_rsp_to_nxt;
    end
  end

  // Next-state: a busy fall on the watchdog's last cycle counts as normal completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      w_state_nxt = w_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (w_timeout) w_state_nxt = bus.m_busy ? ST_DRAIN : ST_RESP;
        else           w_state_nxt = bus.m_busy ? ST_XFER : ST_WAIT_BUSY;
      end
      ST_XFER: begin
        if (!bus.m_busy)   w_state_nxt = ST_RESP;
        else if (w_timeout) w_state_nxt = ST_DRAIN;
        else               w_state_nxt = ST_XFER;
      end
      ST_RESP:      w_state_nxt = ST_IDLE;
      ST_DRAIN:     w_state_nxt = bus.m_busy ? ST_DRAIN : ST_RESP;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values: grant latch, watchdog count, response capture.
  always_comb begin
    w_ptr_nxt           = r_ptr;
    w_owner_nxt         = r_owner;
    w_cnt_nxt           = r_cnt;
    w_req_ready_nxt     = {NUM_REQ{1'b0}};
    w_m_start_nxt       = 1'b0;
    w_m_address_nxt     = r_m_address;
    w_m_write_data_nxt  = r_m_write_data;
    w_m_wlen_nxt        = r_m_wlen;
    w_m_rlen_nxt        = r_m_rlen;
    w_rsp_valid_nxt     = {NUM_REQ{1'b0}};
    w_rsp_read_data_nxt = r_rsp_read_data;
    w_rsp_nr_nxt        = r_rsp_nr;
    w_rsp_to_nxt        = r_rsp_to;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready_nxt    = REQ_ONE << w_win;
          w_m_start_nxt      = 1'b1;
          w_owner_nxt        = w_win;
          w_ptr_nxt          = (w_win == IDX_LAST) ? {IDX_W{1'b0}} : (w_win + IDX_ONE);
          w_m_address_nxt    = bus.req_address[w_win*7 +: 7];
          w_m_write_data_nxt = bus.req_write_data[w_win*DATA_W +: DATA_W];
          w_m_wlen_nxt       = bus.req_write_length[w_win*LEN_W +: LEN_W];
          w_m_rlen_nxt       = bus.req_read_length[w_win*LEN_W +: LEN_W];
        end else begin
          w_owner_nxt = r_owner;
        end
      end
      ST_ISSUE: w_cnt_nxt = {CNT_W{1'b0}};
      ST_WAIT_BUSY, ST_XFER: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if ((r_state == ST_XFER) && !bus.m_busy) begin
          w_rsp_read_data_nxt = bus.m_read_data;
          w_rsp_nr_nxt        = bus.m_no_response;
          w_rsp_to_nxt        = 1'b0;
        end else if (w_timeout) begin
          w_rsp_read_data_nxt = {DATA_W{1'b0}};
          w_rsp_nr_nxt        = 1'b0;
          w_rsp_to_nxt        = 1'b1;
        end else begin
          w_rsp_to_nxt = r_rsp_to;
        end
      end
      ST_RESP:  w_rsp_valid_nxt = REQ_ONE << r_owner;
      ST_DRAIN: w_cnt_nxt = r_cnt;
      default:  w_cnt_nxt = {CNT_W{1'b0}};
    endcase
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.m_start         = r_m_start;
  assign bus.m_address       = r_m_address;
  assign bus.m_write_data    = r_m_write_data;
  assign bus.m_write_length  = r_m_wlen;
  assign bus.m_read_length   = r_m_rlen;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_read_data   = r_rsp_read_data;
  assign bus.rsp_no_response = r_rsp_nr;
  assign bus.rsp_timeout     = r_rsp_to;

endmodule
